// File: rtl/pair_alu_pkg.sv
// Shared types, mode encodings and the two-operand arithmetic helper
// used by the pair-select ALU.
package pair_alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ADD_WRAP = 2'b00;
    localparam logic [1:0] MODE_ADD_SAT  = 2'b01;
    localparam logic [1:0] MODE_SUB_WRAP = 2'b10;
    localparam logic [1:0] MODE_SUB_SAT  = 2'b11;

    // Widest slot value the helper supports; callers zero-extend into it.
    localparam int OP_MAXW = 16;

    // Unsigned add/sub on the low w bits of a and b.
    // Returns {ovf, res}; res is only meaningful in its low w bits.
    function automatic logic [OP_MAXW:0] alu_op(
        input logic [OP_MAXW-1:0] a,
        input logic [OP_MAXW-1:0] b,
        input logic [1:0]         mode,
        input int                 w
    );
        logic [OP_MAXW:0] one;
        logic [OP_MAXW:0] mask;
        logic [OP_MAXW:0] full;
        logic [OP_MAXW:0] res;
        logic             ovf;
        one  = {{OP_MAXW{1'b0}}, 1'b1};
        mask = (one << w) - one;
        if (mode == MODE_ADD_WRAP || mode == MODE_ADD_SAT) begin
            full = {1'b0, a} + {1'b0, b};
            // Carry out of bit w-1 means the sum no longer fits in w bits.
            ovf  = (full > mask);
            res  = (ovf && mode == MODE_ADD_SAT) ? mask : (full & mask);
        end else begin
            full = {1'b0, a} - {1'b0, b};
            ovf  = (a < b);
            res  = (ovf && mode == MODE_SUB_SAT) ? '0 : (full & mask);
        end
        return {ovf, res[OP_MAXW-1:0]};
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Button front end: two-flop synchroniser per button, rising-edge
// detect, and lowest-index-wins selection when several edges coincide.
module btn_edge_sync #(
    parameter  int N    = 10,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    buttons,
    output logic            press_valid,
    output logic [IDXW-1:0] press_idx
);

    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] prev_q,  prev_d;
    logic [N-1:0] rise;

    // Shift chain: raw level -> meta flop -> stable flop -> previous sample.
    always_comb begin
        sync1_d = buttons;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Priority encode: scanning downward leaves the lowest set edge.
    always_comb begin
        press_valid = 1'b0;
        press_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rise[i]) begin
                press_valid = 1'b1;
                press_idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/pair_select_alu.sv
// Two-press operand selector over a register bank: first press picks A,
// second picks B, and A op B is written back into slot A.
module pair_select_alu
    import pair_alu_pkg::*;
#(
    parameter  int N    = 10,
    parameter  int W    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic            load,
    input  logic [N*W-1:0]  load_data,
    input  logic [N-1:0]    buttons,
    output logic [N*W-1:0]  values,
    output logic            sel_valid,
    output logic [IDXW-1:0] sel_index,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    logic            press_valid;
    logic [IDXW-1:0] press_idx;

    state_t          state_q, state_d;
    logic [IDXW-1:0] a_idx_q, a_idx_d;
    logic [IDXW-1:0] b_idx_q, b_idx_d;
    logic [1:0]      mode_q, mode_d;
    logic [W-1:0]    res_q, res_d;
    logic            ovf_res_q, ovf_res_d;
    logic            overflow_q, overflow_d;
    logic [W-1:0]    values_q [N];
    logic [W-1:0]    values_d [N];

    logic [W-1:0]    opa, opb;
    logic [OP_MAXW:0] op_out;
    logic            unused_op_bits;

    btn_edge_sync #(.N(N)) u_btn (
        .clk         (clk),
        .rst_n       (rst_n),
        .buttons     (buttons),
        .press_valid (press_valid),
        .press_idx   (press_idx)
    );

    assign opa            = values_q[a_idx_q];
    assign opb            = values_q[b_idx_q];
    assign op_out         = alu_op(OP_MAXW'(opa), OP_MAXW'(opb), mode_q, W);
    assign unused_op_bits = ^op_out[OP_MAXW-1:W];

    // Next-state, operand capture and bank update; load overrides everything.
    always_comb begin
        state_d    = state_q;
        a_idx_d    = a_idx_q;
        b_idx_d    = b_idx_q;
        mode_d     = mode_q;
        res_d      = res_q;
        ovf_res_d  = ovf_res_q;
        overflow_d = overflow_q;
        values_d   = values_q;

        case (state_q)
            IDLE: begin
                if (enable && press_valid) begin
                    a_idx_d = press_idx;
                    state_d = HAVE_A;
                end
            end
            HAVE_A: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (press_valid) begin
                    if (press_idx == a_idx_q) begin
                        state_d = IDLE;
                    end else begin
                        b_idx_d = press_idx;
                        mode_d  = mode;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    res_d     = op_out[W-1:0];
                    ovf_res_d = op_out[OP_MAXW];
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // A write already underway finishes even if enable drops.
                values_d[a_idx_q] = res_q;
                overflow_d        = ovf_res_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            for (int i = 0; i < N; i++) begin
                values_d[i] = load_data[i*W +: W];
            end
            overflow_d = overflow_q;
            state_d    = IDLE;
        end
    end

    // State, operand and bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_idx_q    <= '0;
            b_idx_q    <= '0;
            mode_q     <= MODE_ADD_WRAP;
            res_q      <= '0;
            ovf_res_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                values_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            a_idx_q    <= a_idx_d;
            b_idx_q    <= b_idx_d;
            mode_q     <= mode_d;
            res_q      <= res_d;
            ovf_res_q  <= ovf_res_d;
            overflow_q <= overflow_d;
            values_q   <= values_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign values[gi*W +: W] = values_q[gi];
    end

    assign sel_valid = (state_q != IDLE);
    assign sel_index = sel_valid ? a_idx_q : '0;
    assign busy      = (state_q == EXEC) || (state_q == WRITE);
    assign done      = (state_q == WRITE) && !load;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pair_select_alu.sv
module tb_pair_select_alu;

    localparam int N = 10;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [1:0]     mode;
    logic           load;
    logic [N*W-1:0] load_data;
    logic [N-1:0]   buttons;
    logic [N*W-1:0] values;
    logic           sel_valid;
    logic [3:0]     sel_index;
    logic           busy;
    logic           done;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         slot;
        logic [3:0] val;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_bank [N];

    pair_select_alu #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .load      (load),
        .load_data (load_data),
        .buttons   (buttons),
        .values    (values),
        .sel_valid (sel_valid),
        .sel_index (sel_index),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        buttons[i] = 1'b1;
        repeat (3) tick();
        buttons[i] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic load_bank();
        for (int i = 0; i < N; i++) load_data[i*W +: W] = exp_bank[i];
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic set_bank_index();
        for (int i = 0; i < N; i++) exp_bank[i] = 4'(i);
    endtask

    task automatic check_bank(input string name);
        logic [N*W-1:0] e;
        for (int i = 0; i < N; i++) e[i*W +: W] = exp_bank[i];
        check(name, 64'(values), 64'(e));
    endtask

    task automatic do_op(input int a, input int b, input logic [1:0] m,
                         input logic [3:0] val, input logic ovf);
        exp_t e;
        mode = m;
        press(a);
        e.slot = a; e.val = val; e.ovf = ovf;
        sb.push_back(e);
        exp_bank[a] = val;
        press(b);
        repeat (3) tick();
        check("op_idle", 64'(busy), 64'(0));
    endtask

    // Monitor: every done pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no write");
            end else begin
                exp_t e;
                e = sb.pop_front();
                @(posedge clk);
                #1;
                check($sformatf("write_slot%0d", e.slot), 64'(values[e.slot*W +: W]), 64'(e.val));
                check("write_ovf", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'b00; load = 1'b0;
        load_data = '0; buttons = '0;
        repeat (2) tick();
        check("rst_values",    64'(values),    64'(0));
        check("rst_sel_valid", 64'(sel_valid), 64'(0));
        check("rst_sel_index", 64'(sel_index), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_done",      64'(done),      64'(0));
        check("rst_overflow",  64'(overflow),  64'(0));
        #3 rst_n = 1'b1;
        tick();
        enable = 1'b1;

        // Test 1: 3 + 5 add-wrap, exact latency, mode change after B ignored.
        set_bank_index();
        load_bank();
        check_bank("preload");
        press(3);
        check("t1_sel_valid", 64'(sel_valid), 64'(1));
        check("t1_sel_index", 64'(sel_index), 64'(3));
        begin
            exp_t e;
            e.slot = 3; e.val = 4'd8; e.ovf = 1'b0;
            sb.push_back(e);
        end
        exp_bank[3] = 4'd8;
        buttons[5] = 1'b1;
        repeat (2) tick();
        buttons[5] = 1'b0;
        check("t1_edge_busy", 64'(busy), 64'(0));
        tick();
        check("t1_exec_busy", 64'(busy), 64'(1));
        check("t1_exec_done", 64'(done), 64'(0));
        mode = 2'b11;
        tick();
        check("t1_write_done", 64'(done), 64'(1));
        tick();
        check("t1_after_done", 64'(done), 64'(0));
        check("t1_sel_clear", 64'(sel_valid), 64'(0));
        check_bank("t1_bank");

        // Test 2: 9 + 9 saturating then wrapping.
        set_bank_index();
        exp_bank[7] = 4'd9; exp_bank[8] = 4'd9;
        load_bank();
        do_op(7, 8, 2'b01, 4'd15, 1'b1);
        exp_bank[7] = 4'd9;
        load_bank();
        do_op(7, 8, 2'b00, 4'd2, 1'b1);
        check_bank("t2_bank");

        // Test 3: 2 - 6 saturating then wrapping.
        set_bank_index();
        load_bank();
        do_op(2, 6, 2'b11, 4'd0, 1'b1);
        set_bank_index();
        load_bank();
        do_op(2, 6, 2'b10, 4'd12, 1'b1);
        check_bank("t3_bank");

        // Test 4: zero-valued slot is selectable; re-press cancels.
        press(0);
        check("t4_sel_valid", 64'(sel_valid), 64'(1));
        check("t4_sel_index", 64'(sel_index), 64'(0));
        press(0);
        check("t4_cancel", 64'(sel_valid), 64'(0));

        // Test 5: simultaneous 1 and 4 -> 1 wins; long hold is one press.
        buttons[1] = 1'b1; buttons[4] = 1'b1;
        repeat (3) tick();
        buttons[1] = 1'b0; buttons[4] = 1'b0;
        repeat (2) tick();
        check("t5_sel_index", 64'(sel_index), 64'(1));
        check("t5_sel_valid", 64'(sel_valid), 64'(1));
        check("t5_not_busy",  64'(busy),      64'(0));
        buttons[1] = 1'b1;
        repeat (100) tick();
        check("t5_hold_once", 64'(sel_valid), 64'(0));
        buttons[1] = 1'b0;
        repeat (3) tick();
        check("t5_release", 64'(sel_valid), 64'(0));

        // Test 6a: enable drop aborts selection; next press starts over.
        press(3);
        enable = 1'b0;
        tick();
        check("t6_enable_abort", 64'(sel_valid), 64'(0));
        enable = 1'b1;
        press(5);
        check("t6_new_a", 64'(sel_index), 64'(5));
        press(5);
        check_bank("t6_bank_held");

        // Test 6b: load during EXEC wins; no write, overflow kept.
        press(3);
        buttons[5] = 1'b1;
        repeat (3) tick();
        check("t6_exec_reached", 64'(busy), 64'(1));
        for (int i = 0; i < N; i++) exp_bank[i] = 4'(15 - i);
        for (int i = 0; i < N; i++) load_data[i*W +: W] = exp_bank[i];
        load = 1'b1;
        tick();
        load = 1'b0;
        buttons[5] = 1'b0;
        repeat (3) tick();
        check("t6_load_idle", 64'(busy), 64'(0));
        check("t6_load_sel",  64'(sel_valid), 64'(0));
        check("t6_load_ovf",  64'(overflow), 64'(1));
        check_bank("t6_load_bank");

        // Test 6c: reset during EXEC clears everything.
        press(3);
        buttons[5] = 1'b1;
        repeat (3) tick();
        check("t6_exec_again", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) exp_bank[i] = 4'd0;
        check_bank("t6_rst_bank");
        check("t6_rst_busy", 64'(busy),      64'(0));
        check("t6_rst_sel",  64'(sel_valid), 64'(0));
        check("t6_rst_ovf",  64'(overflow),  64'(0));
        buttons[5] = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        repeat (5) tick();
        check_bank("t6_post_rst_bank");

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
